// File: rtl/rvm_axi4_wbridge.sv
// rvm_axi4_wbridge: core memory port to AXI4 bridge, posted writes via a small buffer, blocking reads ordered behind drained writes.
module rvm_axi4_wbridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              mem_c_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_b_en,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_error,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_DRAIN, R_ADDR, R_DATA, R_DONE} rstate_t;

    logic [ADDR_W-1:0] r_buf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] r_buf_data [WBUF_DEPTH];
    logic [STRB_W-1:0] r_buf_strb [WBUF_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;
    wstate_t           r_wstate, w_wstate_nx;
    rstate_t           r_rstate, w_rstate_nx;
    logic              r_awvalid, r_wvalid, r_rerr, r_sticky;
    logic [DATA_W-1:0] r_rdata;

    logic w_empty, w_full, w_pop, w_push, w_wr_req, w_rd_req, w_drain_busy;
    logic w_rd_issue, w_start, w_cpl, w_unused;

    assign w_empty      = r_count == '0;
    assign w_full       = r_count == CNT_W'(WBUF_DEPTH);
    assign w_pop        = r_wstate == W_RESP && BVALID;
    assign w_wr_req     = mem_c_en && mem_w_en && r_rstate == R_IDLE;
    assign w_push       = w_wr_req && (!w_full || w_pop);
    assign w_rd_req     = mem_c_en && !mem_w_en;
    assign w_drain_busy = !w_empty || r_wstate != W_IDLE;
    assign w_start      = r_wstate == W_IDLE && !w_empty;
    // An idle read with nothing to drain presents AR in its first cycle to reach the 3-cycle minimum.
    assign w_rd_issue   = r_rstate == R_IDLE && w_rd_req && !w_drain_busy;
    assign w_cpl        = ARESETn && mem_c_en && (w_push || r_rstate == R_DONE);
    assign w_unused     = ^{BRESP[0], RRESP[0]};

    assign mem_stall = mem_c_en && !w_cpl;
    assign mem_error = w_cpl && (r_sticky || (r_rstate == R_DONE && r_rerr));
    assign mem_rdata = r_rdata;
    assign AWADDR    = r_buf_addr[r_rptr];
    assign WDATA     = r_buf_data[r_rptr];
    assign WSTRB     = r_buf_strb[r_rptr];
    assign AWVALID   = r_awvalid;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_wstate == W_RESP;
    assign ARADDR    = mem_addr;
    assign ARVALID   = ARESETn && (r_rstate == R_ADDR || w_rd_issue);
    assign RREADY    = r_rstate == R_DATA;

    always_comb begin
        w_wstate_nx = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (!w_empty) w_wstate_nx = W_SEND;
            W_SEND:  if ((!r_awvalid || AWREADY) && (!r_wvalid || WREADY)) w_wstate_nx = W_RESP;
            W_RESP:  if (BVALID) w_wstate_nx = W_IDLE;
            default: w_wstate_nx = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nx = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_rd_req) w_rstate_nx = w_drain_busy ? R_DRAIN : (ARREADY ? R_DATA : R_ADDR);
            R_DRAIN: if (!w_drain_busy) w_rstate_nx = R_ADDR;
            R_ADDR:  if (ARREADY) w_rstate_nx = R_DATA;
            R_DATA:  if (RVALID) w_rstate_nx = R_DONE;
            R_DONE:  w_rstate_nx = R_IDLE;
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rdata   <= '0;
            r_rerr    <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nx;
            r_rstate  <= w_rstate_nx;
            r_awvalid <= w_start || (r_awvalid && !AWREADY);
            r_wvalid  <= w_start || (r_wvalid && !WREADY);
            r_wptr    <= w_push ? r_wptr + PTR_W'(1) : r_wptr;
            r_rptr    <= w_pop ? r_rptr + PTR_W'(1) : r_rptr;
            r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (r_rstate == R_DATA && RVALID) begin
                r_rdata <= RDATA;
                r_rerr  <= RRESP[1];
            end
            // A fresh write error in the reporting cycle survives the clear.
            r_sticky  <= (w_pop && BRESP[1]) || (r_sticky && !w_cpl);
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_buf_addr[r_wptr] <= mem_addr;
            r_buf_data[r_wptr] <= mem_wdata;
            r_buf_strb[r_wptr] <= mem_b_en;
        end
    end
endmodule

// File: tb/tb_rvm_axi4_wbridge.sv
// tb_rvm_axi4_wbridge: directed scoreboard bench with an AXI slave model for rvm_axi4_wbridge.
module tb_rvm_axi4_wbridge;
    logic        ACLK = 1'b0, ARESETn = 1'b0;
    logic        mem_c_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_b_en = '0;
    logic [31:0] mem_rdata;
    logic        mem_error, mem_stall;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic [3:0]  WSTRB;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY = 1'b1, WREADY = 1'b1, ARREADY = 1'b1;
    logic        BVALID = 1'b0, RVALID = 1'b0;
    logic [1:0]  BRESP = '0, RRESP = '0;
    logic [31:0] RDATA = '0;

    rvm_axi4_wbridge dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .mem_c_en(mem_c_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_b_en(mem_b_en), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .mem_stall(mem_stall),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {bit rd; logic [31:0] data; bit err;} cpl_t;
    typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s;} wr_t;

    cpl_t        exp_cpl[$];
    wr_t         exp_wr[$];
    wr_t         q_w[$];
    logic [31:0] q_aw[$];
    logic [31:0] q_ar[$];
    logic [31:0] mem [logic [31:0]];
    int          tests = 0, fails = 0, outstanding = 0;
    int          b_delay = 0, r_delay = 0;
    logic [1:0]  b_resp = '0, r_resp = '0;
    time         last_b_t = 0;
    bit          ar_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: samples handshakes at the rising edge, drives responses at the falling edge.
    initial begin
        int bt, rt, bpend;
        bit b_done, r_done;
        wr_t w, e;
        logic [31:0] a, m;
        bt = 0; rt = 0; bpend = 0;
        forever begin
            @(posedge ACLK);
            b_done = 0; r_done = 0;
            if (!ARESETn) begin
                q_aw.delete(); q_w.delete(); q_ar.delete();
                bpend = 0; bt = 0; rt = 0; ar_seen = 0;
            end else begin
                if (AWVALID && AWREADY) q_aw.push_back(AWADDR);
                if (WVALID && WREADY) q_w.push_back('{a: '0, d: WDATA, s: WSTRB});
                if (BVALID && BREADY) begin b_done = 1; last_b_t = $time; outstanding--; end
                if (ARVALID && !ar_seen) begin ar_seen = 1; chk("ar_after_b", outstanding, 0); end
                if (ARVALID && ARREADY) begin q_ar.push_back(ARADDR); ar_seen = 0; end
                if (RVALID && RREADY) r_done = 1;
                while (q_aw.size() > 0 && q_w.size() > 0) begin
                    w = q_w.pop_front();
                    w.a = q_aw.pop_front();
                    if (exp_wr.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL bus_write: got unexpected write to %0h", w.a);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("bus_write", {w.a, w.d, w.s}, {e.a, e.d, e.s});
                    end
                    m = mem.exists(w.a) ? mem[w.a] : '0;
                    for (int i = 0; i < 4; i++) if (w.s[i]) m[8*i +: 8] = w.d[8*i +: 8];
                    mem[w.a] = m;
                    bpend++;
                end
            end
            @(negedge ACLK);
            if (!ARESETn) begin
                BVALID = 0; RVALID = 0;
            end else begin
                if (b_done) BVALID = 0;
                if (!BVALID && bpend > 0) begin
                    if (bt >= b_delay) begin BVALID = 1; BRESP = b_resp; bpend--; bt = 0; end
                    else bt++;
                end
                if (r_done) RVALID = 0;
                if (!RVALID && q_ar.size() > 0) begin
                    if (rt >= r_delay) begin
                        a = q_ar.pop_front();
                        RDATA = mem.exists(a) ? mem[a] : '0;
                        RRESP = r_resp; RVALID = 1; rt = 0;
                    end else rt++;
                end
            end
        end
    end

    // Completion monitor: pops the expected response whenever a request completes.
    initial begin
        cpl_t c;
        forever begin
            @(posedge ACLK);
            if (ARESETn) begin
                if (!mem_c_en) chk("stall_idle", mem_stall, 0);
                else if (mem_stall) chk("err_while_stall", mem_error, 0);
                else if (exp_cpl.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL completion: got unexpected completion at %0t", $time);
                end else begin
                    c = exp_cpl.pop_front();
                    if (c.rd) chk("rdata", mem_rdata, c.data);
                    else outstanding++;
                    chk("mem_error", mem_error, c.err);
                end
            end
        end
    end

    task automatic req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] ed, input bit ee, output int stalls, output time t);
        bit done;
        mem_c_en = 1; mem_w_en = we; mem_addr = a; mem_wdata = d; mem_b_en = be;
        exp_cpl.push_back('{rd: !we, data: ed, err: ee});
        if (we) exp_wr.push_back('{a: a, d: d, s: be});
        stalls = 0; done = 0; t = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge ACLK);
            if (!mem_stall) begin done = 1; t = $time; end
            else stalls++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL req_timeout: got no completion for addr %0h expected one", a);
        end
        @(negedge ACLK);
        mem_c_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    initial begin
        int s;
        time t;
        #500000;
        $display("FAIL watchdog: got no end expected summary");
        $fatal(1);
    end

    initial begin
        int s;
        time t;
        idle(2);
        mem_c_en = 1; mem_w_en = 1; #1;
        chk("reset_stall", mem_stall, 1);
        chk("reset_outputs", {AWVALID, WVALID, ARVALID, RREADY, BREADY, mem_error, mem_rdata}, 0);
        mem_c_en = 0; #1;
        chk("reset_stall_idle", mem_stall, 0);
        idle(1);
        ARESETn = 1;

        req(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, s, t);
        chk("wr1_stalls", s, 0);
        idle(1);
        chk("wr1_bus", {AWVALID, WVALID, AWADDR, WDATA, WSTRB}, {2'b11, 32'h100, 32'hDEADBEEF, 4'hF});
        idle(6);
        req(0, 32'h100, 0, 0, 32'hDEADBEEF, 0, s, t);
        chk("rd_min_stalls", s, 2);

        AWREADY = 0;
        for (int i = 0; i < 4; i++) begin
            req(1, 32'h10 + 32'(4 * i), 32'h11110000 + 32'(i), 4'hF, 0, 0, s, t);
            chk("buf_wr_stalls", s, 0);
        end
        fork
            req(1, 32'h20, 32'h55556666, 4'hF, 0, 0, s, t);
            begin idle(4); AWREADY = 1; end
        join
        chk("wr5_stalled", s != 0, 1);
        chk("wr5_at_first_b", t, last_b_t);
        idle(40);

        b_delay = 3; r_delay = 3;
        req(1, 32'h200, 32'h12345678, 4'hF, 0, 0, s, t);
        req(0, 32'h200, 0, 0, 32'h12345678, 0, s, t);
        req(1, 32'h200, 32'hAAAABBBB, 4'h3, 0, 0, s, t);
        req(0, 32'h200, 0, 0, 32'h1234BBBB, 0, s, t);
        r_resp = 2'b10;
        req(0, 32'h200, 0, 0, 32'h1234BBBB, 1, s, t);
        r_resp = 2'b00;
        b_resp = 2'b11;
        req(1, 32'h300, 32'hA5A50F0F, 4'hF, 0, 0, s, t);
        req(0, 32'h300, 0, 0, 32'hA5A50F0F, 1, s, t);
        b_resp = 2'b00;
        req(0, 32'h300, 0, 0, 32'hA5A50F0F, 0, s, t);
        b_delay = 0; r_delay = 0;
        idle(4);

        AWREADY = 0; WREADY = 0;
        req(1, 32'h400, 32'h00000055, 4'hF, 0, 0, s, t);
        idle(2);
        chk("send_before_reset", {AWVALID, WVALID}, 2'b11);
        ARESETn = 0; #1;
        chk("reset_drops_valids", {AWVALID, WVALID}, 2'b00);
        mem_c_en = 1; mem_w_en = 1; #1;
        chk("reset_stall_wr", mem_stall, 1);
        mem_c_en = 0;
        exp_wr.delete(); exp_cpl.delete(); outstanding = 0;
        idle(2);
        ARESETn = 1; AWREADY = 1; WREADY = 1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("empty_after_reset", {AWVALID, WVALID}, 2'b00);
        end
        req(0, 32'h100, 0, 0, 32'hDEADBEEF, 0, s, t);
        chk("rd_after_reset_stalls", s, 2);
        idle(4);
        chk("scoreboard_empty", {32'(exp_cpl.size()), 32'(exp_wr.size())}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
